// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
// Holds the packet codes, PID values, SYNC byte, CRC16 constants and the FSM state enum.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        PKT_DATA0 = 3'd0,
        PKT_ACK   = 3'd1,
        PKT_NAK   = 3'd2,
        PKT_STALL = 3'd3,
        PKT_DATA1 = 3'd4
    } pkt_e;

    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [7:0]  SYNC_BYTE = 8'h80;
    localparam logic [15:0] CRC_POLY  = 16'h8005;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP_SE0,
        ST_EOP_J
    } state_e;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    localparam logic [15:0] CRC_POLY_REFL = reflect16(CRC_POLY);

    // Bits enter LSB first, so the register shifts right against the reflected polynomial.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        return (crc[0] ^ b) ? ((crc >> 1) ^ CRC_POLY_REFL) : (crc >> 1);
    endfunction

    function automatic logic is_data(input logic [2:0] p);
        return (p == PKT_DATA0) || (p == PKT_DATA1);
    endfunction

    function automatic logic [3:0] pid_of(input logic [2:0] p);
        case (p)
            PKT_ACK:   return PID_ACK;
            PKT_NAK:   return PID_NAK;
            PKT_STALL: return PID_STALL;
            PKT_DATA1: return PID_DATA1;
            default:   return PID_DATA0;
        endcase
    endfunction

endpackage

// File: rtl/usb_tx_bit_encoder.sv
// Bit-time engine: times each bit, inserts stuffed zeros and drives the NRZI/SE0 line levels.
// bit_ready marks the edge at which the presented bit is accepted onto the line.
module usb_tx_bit_encoder #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic se0,
    input  logic bit_valid,
    output logic bit_ready,
    output logic dp,
    output logic dm,
    output logic busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;
    logic [2:0]    ones;
    logic          level;
    logic          period_end;
    logic          stuff_due;

    assign period_end = !busy || (cnt == CW'(CLKS_PER_BIT - 1));
    assign stuff_due  = busy && (ones == 3'd6);
    assign bit_ready  = bit_valid && period_end && !stuff_due;

    // SE0 parks the NRZI level at J, so a following raw 1 produces the EOP J bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            ones  <= 3'd0;
            level <= 1'b1;
            dp    <= 1'b1;
            dm    <= 1'b0;
            busy  <= 1'b0;
        end else if (!period_end) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
            if (stuff_due) begin
                level <= ~level;
                dp    <= ~level;
                dm    <= level;
                ones  <= 3'd0;
            end else if (bit_valid && se0) begin
                level <= 1'b1;
                dp    <= 1'b0;
                dm    <= 1'b0;
                ones  <= 3'd0;
                busy  <= 1'b1;
            end else if (bit_valid && bit_in) begin
                dp    <= level;
                dm    <= ~level;
                ones  <= ones + 3'd1;
                busy  <= 1'b1;
            end else if (bit_valid) begin
                level <= ~level;
                dp    <= ~level;
                dm    <= level;
                ones  <= 3'd0;
                busy  <= 1'b1;
            end else begin
                level <= 1'b1;
                dp    <= 1'b1;
                dm    <= 1'b0;
                ones  <= 3'd0;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/usb_tx_param.sv
// USB full-speed transmit encoder: packet FSM, byte shifter, payload counter and serial CRC16.
// Line timing, stuffing and NRZI live in usb_tx_bit_encoder.
module usb_tx_param
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 1,
    parameter int MAX_PKT_BYTES = 64,
    parameter int OCC_W         = $clog2(MAX_PKT_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             TX_Start,
    input  logic [2:0]       TX_Packet,
    input  logic [OCC_W-1:0] Buffer_Occupancy,
    input  logic [7:0]       TX_Packet_Data,
    output logic             Dplus_Out,
    output logic             Dminus_Out,
    output logic             TX_Transfer_Active,
    output logic             TX_Error,
    output logic             Get_TX_Packet_Data
);
    state_e           state;
    logic [2:0]       pkt;
    logic [OCC_W-1:0] len_left;
    logic [15:0]      shreg;
    logic [15:0]      crc;
    logic [15:0]      crc_next;
    logic [3:0]       bit_cnt;
    logic             need_byte;
    logic             err;
    logic             raw_bit;
    logic             se0_req;
    logic             bit_valid;
    logic             bit_ready;
    logic             enc_busy;
    logic             underrun;

    assign underrun = (state == ST_DATA) && need_byte && (Buffer_Occupancy == '0);
    assign crc_next = crc16_step(crc, raw_bit);

    always_comb begin
        raw_bit   = shreg[0];
        se0_req   = 1'b0;
        bit_valid = 1'b1;
        case (state)
            ST_IDLE:    bit_valid = 1'b0;
            ST_DATA: begin
                if (need_byte) begin
                    raw_bit = TX_Packet_Data[0];
                    se0_req = underrun;
                end
            end
            ST_EOP_SE0: se0_req = 1'b1;
            ST_EOP_J:   raw_bit = 1'b1;
            default:    ;
        endcase
    end

    // The pop is qualified by the encoder's accept strobe so it lands on the byte-start boundary.
    assign Get_TX_Packet_Data = (state == ST_DATA) && need_byte && !underrun && bit_ready;
    assign TX_Transfer_Active = enc_busy;
    assign TX_Error           = err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pkt       <= 3'd0;
            len_left  <= '0;
            shreg     <= 16'h0000;
            crc       <= CRC_INIT;
            bit_cnt   <= 4'd0;
            need_byte <= 1'b0;
            err       <= 1'b0;
        end else if (state == ST_IDLE) begin
            // Wait for the encoder to finish the EOP J bit before accepting a new packet.
            if (TX_Start && !enc_busy) begin
                pkt      <= TX_Packet;
                len_left <= Buffer_Occupancy;
                if (TX_Packet > 3'd4) begin
                    err <= 1'b1;
                end else if (is_data(TX_Packet) && (Buffer_Occupancy > OCC_W'(MAX_PKT_BYTES))) begin
                    err <= 1'b1;
                end else begin
                    err       <= 1'b0;
                    state     <= ST_SYNC;
                    shreg     <= {8'h00, SYNC_BYTE};
                    bit_cnt   <= 4'd0;
                    need_byte <= 1'b0;
                end
            end
        end else if (bit_ready) begin
            bit_cnt <= bit_cnt + 4'd1;
            shreg   <= shreg >> 1;
            case (state)
                ST_SYNC: begin
                    if (bit_cnt == 4'd7) begin
                        state   <= ST_PID;
                        shreg   <= {8'h00, ~pid_of(pkt), pid_of(pkt)};
                        bit_cnt <= 4'd0;
                        crc     <= CRC_INIT;
                    end
                end
                ST_PID: begin
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        if (!is_data(pkt)) begin
                            state <= ST_EOP_SE0;
                        end else if (len_left == '0) begin
                            state <= ST_CRC;
                            shreg <= ~crc;
                        end else begin
                            state     <= ST_DATA;
                            need_byte <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (underrun) begin
                        // The first SE0 bit was accepted at this edge.
                        err     <= 1'b1;
                        state   <= ST_EOP_SE0;
                        bit_cnt <= 4'd1;
                    end else begin
                        crc <= crc_next;
                        if (need_byte) begin
                            shreg     <= {9'h000, TX_Packet_Data[7:1]};
                            need_byte <= 1'b0;
                            len_left  <= len_left - 1'b1;
                        end else if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            if (len_left == '0) begin
                                state <= ST_CRC;
                                shreg <= ~crc_next;
                            end else begin
                                need_byte <= 1'b1;
                            end
                        end
                    end
                end
                ST_CRC: begin
                    if (bit_cnt == 4'd15) begin
                        state   <= ST_EOP_SE0;
                        bit_cnt <= 4'd0;
                    end
                end
                ST_EOP_SE0: begin
                    if (bit_cnt == 4'd1) begin
                        state   <= ST_EOP_J;
                        bit_cnt <= 4'd0;
                    end
                end
                ST_EOP_J:   state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    usb_tx_bit_encoder #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_enc (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (raw_bit),
        .se0       (se0_req),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .dp        (Dplus_Out),
        .dm        (Dminus_Out),
        .busy      (enc_busy)
    );

endmodule

// File: tb/tb_usb_tx_param.sv
// Bench for usb_tx_param: a line decoder (NRZI, destuffing, EOP shape) checks directed packets
// on a 1-clock and a 4-clock bit period, plus error, underrun and reset sequences.
module tb_usb_tx_param;
    localparam int MAXB = 64;
    localparam int OW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start1, start4;
    logic [2:0]    pkt;
    logic [OW-1:0] occ;
    logic [7:0]    fdata;
    logic          dp1, dm1, act1, err1, get1;
    logic          dp4, dm4, act4, err4, get4;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    usb_tx_param #(.CLKS_PER_BIT(1), .MAX_PKT_BYTES(MAXB)) dut1 (
        .clk(clk), .rst(rst), .TX_Start(start1), .TX_Packet(pkt),
        .Buffer_Occupancy(occ), .TX_Packet_Data(fdata),
        .Dplus_Out(dp1), .Dminus_Out(dm1), .TX_Transfer_Active(act1),
        .TX_Error(err1), .Get_TX_Packet_Data(get1)
    );

    usb_tx_param #(.CLKS_PER_BIT(4), .MAX_PKT_BYTES(MAXB)) dut4 (
        .clk(clk), .rst(rst), .TX_Start(start4), .TX_Packet(pkt),
        .Buffer_Occupancy(occ), .TX_Packet_Data(fdata),
        .Dplus_Out(dp4), .Dminus_Out(dm4), .TX_Transfer_Active(act4),
        .TX_Error(err4), .Get_TX_Packet_Data(get4)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // ---------------- FIFO model / drivers ----------------
    logic [7:0] pay[16];
    int fifo_idx, fifo_len, cut_at;

    task automatic fifo_drive();
        occ   = (fifo_idx >= cut_at || fifo_idx >= fifo_len) ? '0 : OW'(fifo_len - fifo_idx);
        fdata = (fifo_idx < 16) ? pay[fifo_idx] : 8'h00;
    endtask

    logic [1:0] lv_q[$];
    int get_cnt, act_cyc, rise_idx, timed_out;

    task automatic send(input int sel, input logic [2:0] p, input int n, input int cut);
        logic a, g;
        int guard;
        bit seen;
        fifo_len = n; fifo_idx = 0; cut_at = cut; pkt = p;
        fifo_drive();
        lv_q.delete();
        get_cnt = 0; act_cyc = 0; rise_idx = -1; timed_out = 1;
        @(posedge clk); #1;
        if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        seen = 0;
        for (guard = 0; guard < 2000; guard++) begin
            @(negedge clk);
            a = (sel == 4) ? act4 : act1;
            g = (sel == 4) ? get4 : get1;
            if (a) begin
                if (!seen) rise_idx = guard;
                seen = 1;
                act_cyc++;
                lv_q.push_back((sel == 4) ? {dp4, dm4} : {dp1, dm1});
            end
            if (g) get_cnt++;
            if (seen && !a) begin
                timed_out = 0;
                break;
            end
            @(posedge clk); #1;
            if (g) begin
                fifo_idx++;
                fifo_drive();
            end
        end
    endtask

    // ---------------- line decoder ----------------
    logic [7:0] dec_q[$];
    int stuffs, se0_n, j_n, hold_bad, stuff_bad, sym_bad, left_bits;

    task automatic decode(input int c);
        logic [1:0] s;
        logic [7:0] cur;
        logic prev, b;
        int ones, nb;
        bit in_eop;
        dec_q.delete();
        stuffs = 0; se0_n = 0; j_n = 0; hold_bad = 0; stuff_bad = 0; sym_bad = 0;
        prev = 1'b1; ones = 0; cur = 8'h00; left_bits = 0; in_eop = 0;
        nb = lv_q.size() / c;
        if (lv_q.size() % c != 0) hold_bad++;
        for (int k = 0; k < nb; k++) begin
            s = lv_q[k*c];
            for (int j = 1; j < c; j++) if (lv_q[k*c+j] !== s) hold_bad++;
            if (s == 2'b00) begin
                se0_n++;
                in_eop = 1;
            end else if (in_eop) begin
                if (s == 2'b10) j_n++; else sym_bad++;
            end else if (s == 2'b11) begin
                sym_bad++;
            end else begin
                b = (s[1] == prev);
                prev = s[1];
                if (ones == 6) begin
                    stuffs++;
                    ones = 0;
                    if (b) stuff_bad++;
                end else begin
                    ones = b ? ones + 1 : 0;
                    cur = {b, cur[7:1]};
                    left_bits++;
                    if (left_bits == 8) begin
                        dec_q.push_back(cur);
                        left_bits = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_bytes(input string tag);
        int j;
        logic [7:0] want, got;
        check({tag, "_nbytes"}, dec_q.size(), exp_q.size());
        j = 0;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = (j < dec_q.size()) ? dec_q[j] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, j), got, want);
            j++;
        end
    endtask

    task automatic check_shape(input string tag, input int cyc, input int stf, input int gets);
        check({tag, "_active_cycles"}, act_cyc, cyc);
        check({tag, "_timeout"}, timed_out, 0);
        check({tag, "_start_latency"}, rise_idx, 1);
        check({tag, "_stuffs"}, stuffs, stf);
        check({tag, "_stuff_bit_bad"}, stuff_bad, 0);
        check({tag, "_hold"}, hold_bad, 0);
        check({tag, "_symbols"}, sym_bad, 0);
        check({tag, "_se0_bits"}, se0_n, 2);
        check({tag, "_j_bits"}, j_n, 1);
        check({tag, "_partial_byte"}, left_bits, 0);
        check({tag, "_gets"}, get_cnt, gets);
    endtask

    task automatic err_case(input string tag, input logic [2:0] p, input int o);
        int bad;
        pkt = p; occ = OW'(o);
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (act1 || {dp1, dm1} != 2'b10 || get1) bad++;
        end
        check({tag, "_line_quiet"}, bad, 0);
        check({tag, "_error"}, err1, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         sel;
        logic [2:0] pkt;
        int         n;
        logic [7:0] pid_byte;
        bit         has_crc;
        logic [15:0] crc_tx;
        int         cycles;
        int         stuffs;
        logic [7:0] data[10];
    } vec_t;

    function automatic vec_t mk(input int sel, input logic [2:0] p, input int n,
                                input logic [7:0] pid, input bit hc, input logic [15:0] crc,
                                input int cyc, input int stf);
        vec_t v;
        v.sel = sel; v.pkt = p; v.n = n; v.pid_byte = pid; v.has_crc = hc;
        v.crc_tx = crc; v.cycles = cyc; v.stuffs = stf;
        for (int k = 0; k < 10; k++) v.data[k] = 8'h00;
        return v;
    endfunction

    localparam int NV = 7;
    vec_t vec[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = mk(1, 3'd1, 0, 8'hD2, 0, 16'h0000, 19, 0);
        vec[1] = mk(1, 3'd2, 0, 8'h5A, 0, 16'h0000, 19, 0);
        vec[2] = mk(1, 3'd3, 0, 8'h1E, 0, 16'h0000, 19, 0);
        vec[3] = mk(1, 3'd0, 0, 8'hC3, 1, 16'h0000, 35, 0);
        vec[4] = mk(1, 3'd4, 9, 8'h4B, 1, 16'hB4C8, 107, 0);
        for (int k = 0; k < 9; k++) vec[4].data[k] = 8'h31 + 8'(k);
        vec[5] = mk(1, 3'd0, 2, 8'hC3, 1, 16'hFFFF, 56, 5);
        vec[5].data[0] = 8'hFF; vec[5].data[1] = 8'hFF;
        vec[6] = mk(4, 3'd1, 0, 8'hD2, 0, 16'h0000, 76, 0);

        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; pkt = 3'd0; occ = '0; fdata = 8'h00;
        for (int k = 0; k < 16; k++) pay[k] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dut1", {dp1, dm1, act1, err1, get1}, 5'b10000);
        check("reset_dut4", {dp4, dm4, act4, err4, get4}, 5'b10000);
        @(posedge clk); #1;
        rst = 1'b0;

        err_case("err_oversize", 3'd0, 65);
        err_case("err_illegal", 3'd6, 0);

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < 10; k++) pay[k] = vec[i].data[k];
            for (int k = 10; k < 16; k++) pay[k] = 8'h00;
            send(vec[i].sel, vec[i].pkt, vec[i].n, 99);
            decode(vec[i].sel);
            exp_q.push_back(8'h80);
            exp_q.push_back(vec[i].pid_byte);
            for (int k = 0; k < vec[i].n; k++) exp_q.push_back(vec[i].data[k]);
            if (vec[i].has_crc) begin
                exp_q.push_back(vec[i].crc_tx[7:0]);
                exp_q.push_back(vec[i].crc_tx[15:8]);
            end
            check_shape($sformatf("v%0d", i), vec[i].cycles, vec[i].stuffs, vec[i].n);
            check($sformatf("v%0d_error_clear", i), (vec[i].sel == 4) ? err4 : err1, 0);
            compare_bytes($sformatf("v%0d", i));
        end

        // Underrun: latched length 4, FIFO runs dry after two bytes.
        pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'h56; pay[3] = 8'h78;
        send(1, 3'd0, 4, 2);
        decode(1);
        exp_q.push_back(8'h80); exp_q.push_back(8'hC3);
        exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        check_shape("underrun", 35, 0, 2);
        check("underrun_error", err1, 1);
        compare_bytes("underrun");

        // Asynchronous reset in the middle of a DATA1 payload.
        for (int k = 0; k < 9; k++) pay[k] = 8'h31 + 8'(k);
        fifo_len = 9; fifo_idx = 0; cut_at = 99; pkt = 3'd4;
        fifo_drive();
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int guard = 0; guard < 500 && fifo_idx < 3; guard++) begin
            logic g;
            @(negedge clk);
            g = get1;
            @(posedge clk); #1;
            if (g) begin
                fifo_idx++;
                fifo_drive();
            end
        end
        check("rst_reached_data", fifo_idx, 3);
        #2;
        check("rst_pre_active", act1, 1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {dp1, dm1, act1, err1, get1}, 5'b10000);
        @(negedge clk);
        check("rst_held_outputs", {dp1, dm1, act1, err1, get1}, 5'b10000);
        @(posedge clk); #1;
        rst = 1'b0;

        send(1, 3'd1, 0, 99);
        decode(1);
        exp_q.push_back(8'h80); exp_q.push_back(8'hD2);
        check_shape("post_rst_ack", 19, 0, 0);
        compare_bytes("post_rst_ack");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
